// File: rtl/dom_pg_pkg.sv
// Shared helpers for the masked pass-gate XOR pipeline.
//
// Purpose : sizing helpers and the share-pair index mapping used by the
//           DOM-indep AND stages and the top-level pipeline.
// Contents: np()       - number of share pairs, SHARES*(SHARES-1)/2
//           rnd_w()    - fresh random bits needed per transaction
//           pair_idx() - lexicographic index k of share pair (i<j)
//           LATENCY    - advance cycles from input accept to output valid
package dom_pg_pkg;

   localparam int LATENCY = 3;

   function automatic int np(input int shares);
      return shares * (shares - 1) / 2;
   endfunction

   function automatic int rnd_w(input int shares, input int width);
      return 3 * np(shares) * width;
   endfunction

   // Pairs (0,1),(0,2)..(0,n-1),(1,2).. numbered 0,1,2.. in that order.
   function automatic int pair_idx(input int i, input int j, input int shares);
      return i * (2 * shares - i - 1) / 2 + (j - i - 1);
   endfunction

endpackage

// File: rtl/dom_and_stage.sv
// One DOM-indep AND gadget layer with its register barrier.
//
// Purpose : computes per-domain product terms of two Boolean-shared operands,
//           blinds every cross-domain term with the fresh random word shared
//           by its pair, and registers all terms. The registered terms are
//           compressed (XOR within each domain) combinationally on comp_o.
// Ports   : clk, rst_n - clock, asynchronous active-low reset
//           en         - load enable (pipeline advance)
//           clr        - load zeros instead of fresh terms when enabled
//           a_sh, b_sh - operand shares, share s at [s*WIDTH +: WIDTH]
//           rnd        - NP*WIDTH random bits, pair k at [k*WIDTH +: WIDTH]
//           prod_o     - registered terms, domain i / term j at
//                        [(i*SHARES+j)*WIDTH +: WIDTH]
//           comp_o     - per-domain XOR of the registered terms
module dom_and_stage
   import dom_pg_pkg::*;
#(
   parameter int SHARES = 2,
   parameter int WIDTH  = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             en,
   input  logic                             clr,
   input  logic [SHARES*WIDTH-1:0]          a_sh,
   input  logic [SHARES*WIDTH-1:0]          b_sh,
   input  logic [np(SHARES)*WIDTH-1:0]      rnd,
   output logic [SHARES*SHARES*WIDTH-1:0]   prod_o,
   output logic [SHARES*WIDTH-1:0]          comp_o
);

   logic [SHARES*SHARES*WIDTH-1:0] term_d;
   logic [SHARES*SHARES*WIDTH-1:0] term_q;

   // Domain i owns a_i & b_j. Both halves of a cross pair share r_k, so the
   // mask cancels once all domains are recombined.
   always_comb begin
      term_d = '0;
      for (int i = 0; i < SHARES; i++) begin
         for (int j = 0; j < SHARES; j++) begin
            if (i == j) begin
               term_d[(i*SHARES+j)*WIDTH +: WIDTH] =
                  a_sh[i*WIDTH +: WIDTH] & b_sh[i*WIDTH +: WIDTH];
            end else if (i < j) begin
               term_d[(i*SHARES+j)*WIDTH +: WIDTH] =
                  (a_sh[i*WIDTH +: WIDTH] & b_sh[j*WIDTH +: WIDTH]) ^
                  rnd[pair_idx(i, j, SHARES)*WIDTH +: WIDTH];
            end else begin
               term_d[(i*SHARES+j)*WIDTH +: WIDTH] =
                  (a_sh[i*WIDTH +: WIDTH] & b_sh[j*WIDTH +: WIDTH]) ^
                  rnd[pair_idx(j, i, SHARES)*WIDTH +: WIDTH];
            end
         end
      end
   end

   // Register barrier: stops glitches from combining unmasked cross terms.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         term_q <= '0;
      end else if (en) begin
         if (clr) term_q <= '0;
         else     term_q <= term_d;
      end
   end

   always_comb begin
      comp_o = '0;
      for (int i = 0; i < SHARES; i++) begin
         for (int j = 0; j < SHARES; j++) begin
            comp_o[i*WIDTH +: WIDTH] = comp_o[i*WIDTH +: WIDTH] ^
                                       term_q[(i*SHARES+j)*WIDTH +: WIDTH];
         end
      end
   end

   assign prod_o = term_q;

endmodule

// File: rtl/dom_xor_pg_pipe.sv
// Pipelined glitch-robust masked XOR (pass-gate form) for SHARES shares.
//
// Purpose : y = (a & ~b) ^ (~a & b) ^ ((a & ~b) & (~a & b)) on Boolean shares,
//           built from three DOM-indep AND layers separated by registers.
//           Recombined result equals a ^ b for any randomness.
// Ports   : clk, rst_n          - clock, asynchronous active-low reset
//           in_valid_i/in_ready_o   - input share stream handshake
//           a_sh_i, b_sh_i          - operand shares, share s at [s*WIDTH +: WIDTH]
//           rnd_valid_i/rnd_ready_o - randomness handshake
//           rnd_i                   - 3*NP*WIDTH fresh bits: AND1, AND1', AND2
//           out_valid_o/out_ready_i - output share stream handshake
//           y_sh_o                  - result shares, same layout
// Build option: define PG_ZEROIZE_EN to load zeros into every stage that
//           receives a bubble, so no stale share data stays resident.
// Latency : 3 advance cycles; 1 transaction per cycle when not stalled.
module dom_xor_pg_pipe
   import dom_pg_pkg::*;
#(
   parameter int SHARES = 2,
   parameter int WIDTH  = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid_i,
   output logic                              in_ready_o,
   input  logic [SHARES*WIDTH-1:0]           a_sh_i,
   input  logic [SHARES*WIDTH-1:0]           b_sh_i,
   input  logic                              rnd_valid_i,
   output logic                              rnd_ready_o,
   input  logic [rnd_w(SHARES, WIDTH)-1:0]   rnd_i,
   output logic                              out_valid_o,
   input  logic                              out_ready_i,
   output logic [SHARES*WIDTH-1:0]           y_sh_o
);

   localparam int NPW = np(SHARES) * WIDTH;
   localparam int SW  = SHARES * WIDTH;
   localparam int PW  = SHARES * SHARES * WIDTH;

   logic          advance;
   logic          vld_p1;
   logic          vld_p2;
   logic          clr_s1;
   logic          clr_s2;
   logic          clr_s3;
   logic [SW-1:0] a_n;
   logic [SW-1:0] b_n;
   logic [SW-1:0] x_comp;
   logic [SW-1:0] z_comp;
   logic [SW-1:0] t_comp;
   logic [SW-1:0] x_sh_p2;
   logic [SW-1:0] z_sh_p2;
   logic [SW-1:0] y_d;
   logic [PW-1:0] x_prod_unused;
   logic [PW-1:0] z_prod_unused;
   logic [PW-1:0] t_prod_unused;

   // Randomness is tied to the whole pipeline moving, never to in_valid_i,
   // so bubbles still consume (and are blinded by) fresh bits.
   assign advance     = rnd_valid_i & (~out_valid_o | out_ready_i);
   assign in_ready_o  = advance;
   assign rnd_ready_o = advance;

`ifdef PG_ZEROIZE_EN
   assign clr_s1 = ~in_valid_i;
   assign clr_s2 = ~vld_p1;
   assign clr_s3 = ~vld_p2;
`else
   assign clr_s1 = 1'b0;
   assign clr_s2 = 1'b0;
   assign clr_s3 = 1'b0;
`endif

   // Masked NOT touches share 0 only.
   always_comb begin
      a_n            = a_sh_i;
      b_n            = b_sh_i;
      a_n[WIDTH-1:0] = ~a_sh_i[WIDTH-1:0];
      b_n[WIDTH-1:0] = ~b_sh_i[WIDTH-1:0];
   end

   // ---- S1: x = a & ~b and z = ~a & b product registers ----
   dom_and_stage #(.SHARES(SHARES), .WIDTH(WIDTH)) u_and_x (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (advance),
      .clr    (clr_s1),
      .a_sh   (a_sh_i),
      .b_sh   (b_n),
      .rnd    (rnd_i[0 +: NPW]),
      .prod_o (x_prod_unused),
      .comp_o (x_comp)
   );

   dom_and_stage #(.SHARES(SHARES), .WIDTH(WIDTH)) u_and_z (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (advance),
      .clr    (clr_s1),
      .a_sh   (a_n),
      .b_sh   (b_sh_i),
      .rnd    (rnd_i[NPW +: NPW]),
      .prod_o (z_prod_unused),
      .comp_o (z_comp)
   );

   // ---- S2: compressed x/z shares and t = x & z product registers ----
   // The AND2 slice of rnd_i belongs to the transaction currently in S1.
   dom_and_stage #(.SHARES(SHARES), .WIDTH(WIDTH)) u_and_t (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (advance),
      .clr    (clr_s2),
      .a_sh   (x_comp),
      .b_sh   (z_comp),
      .rnd    (rnd_i[2*NPW +: NPW]),
      .prod_o (t_prod_unused),
      .comp_o (t_comp)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_sh_p2 <= '0;
         z_sh_p2 <= '0;
      end else if (advance) begin
         if (clr_s2) begin
            x_sh_p2 <= '0;
            z_sh_p2 <= '0;
         end else begin
            x_sh_p2 <= x_comp;
            z_sh_p2 <= z_comp;
         end
      end
   end

   // ---- S3: per-domain y = x ^ z ^ compress(t) output register ----
   assign y_d = x_sh_p2 ^ z_sh_p2 ^ t_comp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_sh_o <= '0;
      end else if (advance) begin
         if (clr_s3) y_sh_o <= '0;
         else        y_sh_o <= y_d;
      end
   end

   // Valid chain moves in lockstep with the data registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1      <= 1'b0;
         vld_p2      <= 1'b0;
         out_valid_o <= 1'b0;
      end else if (advance) begin
         vld_p1      <= in_valid_i;
         vld_p2      <= vld_p1;
         out_valid_o <= vld_p2;
      end
   end

endmodule
